gpr_write_arbiter: RTL

GPR_WRITE_ARBITER -- requirements
Module: gpr_write_arbiter

---
 rtl/gpr_write_arbiter_pkg.sv | 36 +++
 rtl/gpr_util_defs.sv | 12 +
 rtl/gpr_write_arbiter_pick.sv | 34 +++
 rtl/gpr_write_arbiter.sv | 101 ++++++++++
 4 files changed

// File: rtl/gpr_write_arbiter_pkg.sv
// Types and helpers shared by the GPR write arbiter and its grant picker.
`ifndef GPR_UTIL_DEFS_SV
`include "gpr_util_defs.sv"
`endif

package gpr_write_arbiter_pkg;

    // Identifies which writeback source won a grant.
    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_sel_e;

    // One write-port transaction as seen by the GPR file.
    typedef struct packed {
        logic                  enable;
        logic [`REGS_ADDR_BUS] addr;
        logic [`REGS_DATA_BUS] data;
    } gpr_write_t;

    localparam gpr_write_t WRITE_IDLE = '0;

    // Register 0 is hardwired; a granted write to it becomes an idle cycle.
    function automatic gpr_write_t make_write(input logic [`REGS_ADDR_BUS] addr,
                                              input logic [`REGS_DATA_BUS] data);
        gpr_write_t w;
        w = WRITE_IDLE;
        if (addr != '0) begin
            w.enable = `ENABLE;
            w.addr   = addr;
            w.data   = data;
        end
        return w;
    endfunction

endpackage

// File: rtl/gpr_util_defs.sv
// Shared utility macros for the GPR write path: enable levels and register
// file bus widths. Guarded so every consumer can pull it in safely.
`ifndef GPR_UTIL_DEFS_SV
`define GPR_UTIL_DEFS_SV

`define ENABLE        1'b1
`define DISABLE       1'b0
`define REGS_ADDR_BUS 4:0
`define REGS_DATA_BUS 31:0
`define REGS_NUM_LOG  5

`endif

// File: rtl/gpr_write_arbiter_pick.sv
// Combinational two-way grant picker for the GPR write arbiter.
// prio high prefers request 1, low prefers request 0; stall blocks both.
`ifndef GPR_UTIL_DEFS_SV
`include "gpr_util_defs.sv"
`endif

module gpr_arb_pick (
    input  logic valid0,
    input  logic valid1,
    input  logic stall,
    input  logic prio,
    output logic grant0,
    output logic grant1
);

    // A lone requester always wins; contention is settled by prio.
    always_comb begin
        grant0 = `DISABLE;
        grant1 = `DISABLE;
        if (!stall) begin
            if (valid0 && valid1) begin
                if (prio) begin
                    grant1 = `ENABLE;
                end else begin
                    grant0 = `ENABLE;
                end
            end else begin
                grant0 = valid0;
                grant1 = valid1;
            end
        end
    end

endmodule

// File: rtl/gpr_write_arbiter.sv
// GPR write-port arbiter: merges execute writeback (req0) and load return
// (req1) onto the single register-file write port with one cycle latency.
// Optional feature: define GPR_ARB_ROUND_ROBIN_EN for round-robin priority;
// otherwise the load return has fixed priority.
`ifndef GPR_UTIL_DEFS_SV
`include "gpr_util_defs.sv"
`endif

module gpr_write_arbiter
    import gpr_write_arbiter_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  req0_valid,
    input  logic [`REGS_ADDR_BUS] req0_addr,
    input  logic [`REGS_DATA_BUS] req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [`REGS_ADDR_BUS] req1_addr,
    input  logic [`REGS_DATA_BUS] req1_data,
    output logic                  req1_ready,
    output logic                  write_enable,
    output logic [`REGS_ADDR_BUS] write_addr,
    output logic [`REGS_DATA_BUS] write_data,
    output logic                  collision
);

    logic       req0_live;
    logic       req1_live;
    logic       grant0;
    logic       grant1;
    logic       prio_req1;
    gpr_write_t wr_d;
    gpr_write_t wr_q;
    logic       collision_q;

    // Reset masks the requests so no grant can be issued while it is held.
    assign req0_live = req0_valid & ~reset;
    assign req1_live = req1_valid & ~reset;

    gpr_arb_pick u_pick (
        .valid0 (req0_live),
        .valid1 (req1_live),
        .stall  (stall),
        .prio   (prio_req1),
        .grant0 (grant0),
        .grant1 (grant1)
    );

    assign req0_ready = grant0;
    assign req1_ready = grant1;

`ifdef GPR_ARB_ROUND_ROBIN_EN
    req_sel_e last_grant_q;

    // Remember the latest winner; starts as REQ1 so request 0 leads after reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant_q <= REQ1;
        end else if (grant0) begin
            last_grant_q <= REQ0;
        end else if (grant1) begin
            last_grant_q <= REQ1;
        end
    end

    assign prio_req1 = (last_grant_q == REQ0);
`else
    assign prio_req1 = `ENABLE;
`endif

    // Select the granted payload; zero-address writes collapse to idle.
    always_comb begin
        wr_d = WRITE_IDLE;
        if (grant1) begin
            wr_d = make_write(req1_addr, req1_data);
        end else if (grant0) begin
            wr_d = make_write(req0_addr, req0_data);
        end
    end

    // Write-port and collision registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_q        <= WRITE_IDLE;
            collision_q <= `DISABLE;
        end else begin
            wr_q        <= wr_d;
            collision_q <= req0_valid & req1_valid & ~stall;
        end
    end

    // A reset arriving right after a handshake must discard that pending write,
    // so the registered port is masked while reset is high.
    assign write_enable = wr_q.enable & ~reset;
    assign write_addr   = reset ? '0 : wr_q.addr;
    assign write_data   = reset ? '0 : wr_q.data;
    assign collision    = collision_q & ~reset;

endmodule
